pulse_measure: RTL and testbench

Receive-side counterpart of the pulse widener: samples a level input, measures the length in clock cycles of each high run, and presents each completed measurement on a valid/ready output. Runs shorter than a programmable minimum are rejected as glitches. Sits at the consumer end of widened or stretched event lines, recovering run length for downstream counters and debug logic.

---
 rtl/pulse_measure_pkg.sv | 11 +
 rtl/pulse_measure_if.sv | 12 +
 rtl/pulse_measure_sat_counter.sv | 30 +++
 rtl/pulse_measure.sv | 99 +++++++++
 tb/tb_pulse_measure.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/pulse_measure_pkg.sv
// Shared types and constants for the pulse_measure block.
package pulse_measure_pkg;

  typedef enum logic {IDLE, COUNT} pm_state_t;

  // All-ones value of a w-bit counter, i.e. the saturation point 2^w-1.
  function automatic int unsigned sat_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/pulse_measure_if.sv
// Result handshake bus: measured width plus saturation flag under valid/ready.
interface pulse_measure_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] width;
  logic         sat;
  logic         valid;
  logic         ready;

  modport master (output width, output sat, output valid, input ready);
  modport slave  (input width, input sat, input valid, output ready);
endinterface

// File: rtl/pulse_measure_sat_counter.sv
// W-bit run-length counter: load-to-1, saturating increment, at-max flag.
module sat_counter
  import pulse_measure_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         at_max
);

  localparam logic [W-1:0] MAX_CNT = W'(sat_max(W));

  assign at_max = (cnt == MAX_CNT);

  // Load starts a new run at 1; increments stop at the all-ones value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(1);
    end else if (inc && !at_max) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_measure.sv
// Measures the length of each high run on `in` and reports it on a
// depth-1 valid/ready result register; short runs are dropped as glitches.
module pulse_measure
  import pulse_measure_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned MIN_LEN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in,
  output logic            busy,
  output logic            overflow,
  pulse_measure_if.master res
);

  localparam logic [W-1:0] MIN_CNT = W'(MIN_LEN);

  pm_state_t    state;
  pm_state_t    state_next;
  logic         load;
  logic         inc;
  logic         done;
  logic [W-1:0] cnt;
  logic         sat_run;
  logic         keep;
  logic         take;

  // The counter saturates and is reloaded to 1 on entry to COUNT, so its
  // at-max flag is exactly "this run has reached 2^W-1".
  sat_counter #(
    .W(W)
  ) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .load   (load),
    .inc    (inc),
    .cnt    (cnt),
    .at_max (sat_run)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and counter control; done pulses on the falling sample.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    inc        = 1'b0;
    done       = 1'b0;
    unique case (state)
      IDLE: begin
        if (in) begin
          state_next = COUNT;
          load       = 1'b1;
        end
      end
      COUNT: begin
        if (in) begin
          inc = 1'b1;
        end else begin
          state_next = IDLE;
          done       = 1'b1;
        end
      end
    endcase
  end

  assign busy = (state == COUNT);
  assign keep = done && (cnt >= MIN_CNT);
  assign take = res.valid && res.ready;

  // Output register: load when empty or draining, else drop and flag overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res.width <= '0;
      res.sat   <= 1'b0;
      res.valid <= 1'b0;
      overflow  <= 1'b0;
    end else if (keep) begin
      if (!res.valid || res.ready) begin
        res.width <= cnt;
        res.sat   <= sat_run;
        res.valid <= 1'b1;
      end else begin
        overflow <= 1'b1;
      end
    end else if (take) begin
      res.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pulse_measure.sv
// Bench for pulse_measure: two instances (W=8/MIN_LEN=2, W=4/MIN_LEN=3)
// share one stimulus stream; a run-length reference model feeds result
// queues that a negedge monitor drains as the DUTs present results.
module tb_pulse_measure;

  logic clk = 1'b0;
  logic rst;
  logic in;
  logic ready;

  always #5 clk = ~clk;

  pulse_measure_if #(.W(8)) bus8 ();
  pulse_measure_if #(.W(4)) bus4 ();
  assign bus8.ready = ready;
  assign bus4.ready = ready;

  logic busy8, ovf8, busy4, ovf4;

  pulse_measure #(.W(8), .MIN_LEN(2)) dut8 (
    .clk(clk), .rst(rst), .in(in), .busy(busy8), .overflow(ovf8), .res(bus8)
  );
  pulse_measure #(.W(4), .MIN_LEN(3)) dut4 (
    .clk(clk), .rst(rst), .in(in), .busy(busy4), .overflow(ovf4), .res(bus4)
  );

  logic [7:0] d_width [2];
  logic       d_sat   [2];
  logic       d_valid [2];
  logic       d_busy  [2];
  logic       d_ovf   [2];
  assign d_width[0] = bus8.width;
  assign d_width[1] = {4'b0000, bus4.width};
  assign d_sat[0]   = bus8.sat;
  assign d_sat[1]   = bus4.sat;
  assign d_valid[0] = bus8.valid;
  assign d_valid[1] = bus4.valid;
  assign d_busy[0]  = busy8;
  assign d_busy[1]  = busy4;
  assign d_ovf[0]   = ovf8;
  assign d_ovf[1]   = ovf4;

  function automatic int maxv(input int i);
    return (i == 0) ? 255 : 15;
  endfunction
  function automatic int minl(input int i);
    return (i == 0) ? 2 : 3;
  endfunction
  function automatic int wbits(input int i);
    return (i == 0) ? 8 : 4;
  endfunction

  typedef struct packed {
    logic [7:0] width;
    logic       sat;
  } res_t;

  res_t q0[$];
  res_t q1[$];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [W=%0d] actual=%0d required=%0d at t=%0t", name, wbits(i), act, exp, $time);
    end
  endtask

  function automatic void push_res(input int i, input res_t r);
    if (i == 0) q0.push_back(r); else q1.push_back(r);
  endfunction
  function automatic int qsize(input int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction
  function automatic res_t pop_res(input int i);
    return (i == 0) ? q0.pop_front() : q1.pop_front();
  endfunction

  // Reference model: length of the current high run plus each instance's
  // pending/overflow view of its single result slot.
  int run_len = 0;
  bit m_valid [2];
  bit m_ovf   [2];

  initial begin
    m_valid[0] = 0; m_valid[1] = 0; m_ovf[0] = 0; m_ovf[1] = 0;
    forever begin
      int L;
      bit done;
      @(posedge clk or posedge rst);
      if (rst) begin
        run_len = 0;
        for (int i = 0; i < 2; i++) begin
          m_valid[i] = 0;
          m_ovf[i]   = 0;
        end
        q0.delete();
        q1.delete();
      end else begin
        done = 0;
        L    = 0;
        if (in) begin
          run_len++;
        end else if (run_len > 0) begin
          L       = run_len;
          run_len = 0;
          done    = 1;
        end
        for (int i = 0; i < 2; i++) begin
          if (done && L >= minl(i)) begin
            if (!m_valid[i] || ready) begin
              res_t r;
              r.width = 8'((L > maxv(i)) ? maxv(i) : L);
              r.sat   = (L >= maxv(i));
              push_res(i, r);
              m_valid[i] = 1;
            end else begin
              m_ovf[i] = 1;
            end
          end else if (m_valid[i] && ready) begin
            m_valid[i] = 0;
          end
        end
      end
    end
  end

  // Monitor: a result is new when valid was low last cycle or the previous
  // one was just consumed; held results must stay stable.
  bit   prev_valid [2];
  res_t held       [2];

  initial begin
    prev_valid[0] = 0; prev_valid[1] = 0;
    held[0] = '0; held[1] = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid[0] = 0;
        prev_valid[1] = 0;
      end else begin
        for (int i = 0; i < 2; i++) begin
          check("busy", i, 32'(d_busy[i]), 32'(run_len > 0));
          check("overflow", i, 32'(d_ovf[i]), 32'(m_ovf[i]));
          check("valid", i, 32'(d_valid[i]), 32'(m_valid[i]));
          if (d_valid[i] === 1'b1) begin
            if (!prev_valid[i] || ready) begin
              if (qsize(i) == 0) begin
                check("unexpected_result", i, 32'(1), 32'(0));
              end else begin
                held[i] = pop_res(i);
              end
            end
            check("width", i, 32'(d_width[i]), 32'(held[i].width));
            check("sat", i, 32'(d_sat[i]), 32'(held[i].sat));
          end
          prev_valid[i] = (d_valid[i] === 1'b1);
        end
      end
    end
  end

  task automatic cyc(input logic v_in, input logic v_rdy);
    @(negedge clk);
    #1;
    in    = v_in;
    ready = v_rdy;
  endtask

  task automatic run(input int hi, input int lo, input logic v_rdy);
    for (int k = 0; k < hi; k++) cyc(1'b1, v_rdy);
    for (int k = 0; k < lo; k++) cyc(1'b0, v_rdy);
  endtask

  task automatic check_reset();
    for (int i = 0; i < 2; i++) begin
      check("rst_width", i, 32'(d_width[i]), 32'(0));
      check("rst_sat", i, 32'(d_sat[i]), 32'(0));
      check("rst_valid", i, 32'(d_valid[i]), 32'(0));
      check("rst_busy", i, 32'(d_busy[i]), 32'(0));
      check("rst_overflow", i, 32'(d_ovf[i]), 32'(0));
    end
  endtask

  initial begin
    rst   = 1'b1;
    in    = 1'b0;
    ready = 1'b1;
    repeat (2) @(negedge clk);
    check_reset();
    #1 rst = 1'b0;

    run(5, 3, 1'b1);                 // basic 5-cycle run
    run(1, 3, 1'b1);                 // glitch below both minimums
    run(20, 1, 1'b1);                // saturates the 4-bit instance
    run(3, 3, 1'b1);
    run(3, 2, 1'b0);                 // first result held
    run(6, 2, 1'b0);                 // second result dropped
    run(0, 3, 1'b1);                 // drain; overflow stays set
    run(4, 1, 1'b1);                 // back-to-back runs
    run(2, 3, 1'b1);
    run(300, 2, 1'b1);               // saturates the 8-bit instance

    // Asynchronous reset mid-run with a result pending, input still high.
    run(4, 1, 1'b0);
    run(3, 0, 1'b0);
    #1 rst = 1'b1;
    #1 check_reset();
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b1);
    @(negedge clk);
    #1 rst = 1'b0;
    run(3, 3, 1'b1);

    for (int n = 0; n < 300; n++) begin
      int hi;
      int lo;
      hi = ($urandom_range(0, 19) == 0) ? int'($urandom_range(250, 270)) : int'($urandom_range(1, 18));
      lo = int'($urandom_range(1, 4));
      for (int k = 0; k < hi + lo; k++) begin
        cyc(k < hi, $urandom_range(0, 9) < 7);
      end
    end

    run(0, 10, 1'b1);
    for (int i = 0; i < 2; i++) begin
      check("leftover_results", i, 32'(qsize(i)), 32'(0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
